// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } vend_state_e;

    localparam logic [1:0] COIN_5   = 2'd0;
    localparam logic [1:0] COIN_10  = 2'd1;
    localparam logic [1:0] COIN_25  = 2'd2;
    localparam logic [1:0] COIN_BAD = 2'd3;

    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;
    localparam int unsigned VAL_25 = 25;

    // Invalid codes are worth nothing.
    function automatic int unsigned coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return VAL_5;
            COIN_10: return VAL_10;
            COIN_25: return VAL_25;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change-coin picker: largest coin not exceeding the given credit.
module vend_change_sel
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          coin
);

    always_comb begin
        coin = COIN_5;
        if (credit >= CREDIT_W'(VAL_25)) begin
            coin = COIN_25;
        end else if (credit >= CREDIT_W'(VAL_10)) begin
            coin = COIN_10;
        end
    end

endmodule

// File: rtl/vending_multi.sv
// Multi-product vending controller: coin credit, priced selection, one-cycle
// vend pulse and coin-by-coin change payout with handshake. All outputs registered.
module vending_multi
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd10, 8'd15, 8'd20, 8'd25},
    localparam int SEL_W = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_en,
    input  logic [1:0]          coin_val,
    input  logic                sel_en,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic [N_ITEMS-1:0]  stock_empty,
    input  logic                chg_ack,
    output logic                dispense,
    output logic [SEL_W-1:0]    disp_item,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy
);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [SEL_W-1:0]    disp_item_q, disp_item_d;
    logic                chg_valid_q, chg_valid_d;
    logic [1:0]          chg_coin_q, chg_coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                sel_hit;
    logic                sel_empty;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;
    logic [1:0]          greedy_coin;

    // Price/stock lookup by search so out-of-range selections never index past the tables.
    always_comb begin
        sel_hit   = 1'b0;
        sel_empty = 1'b0;
        sel_price = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_hit   = 1'b1;
                sel_empty = stock_empty[i];
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
        sel_ok = sel_hit && !sel_empty && (credit_q >= sel_price);
    end

    always_comb begin
        coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_val));
        coin_ok  = (coin_val != COIN_BAD) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    end

    vend_change_sel #(
        .CREDIT_W(CREDIT_W)
    ) u_change_sel (
        .credit(credit_d),
        .coin  (greedy_coin)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        dispense_d    = 1'b0;
        disp_item_d   = '0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_en) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_en;
                end else if (sel_en) begin
                    // A selection attempt, accepted or refused, drops any same-cycle coin.
                    coin_reject_d = coin_en;
                    if (sel_ok) begin
                        state_d     = S_VEND;
                        dispense_d  = 1'b1;
                        disp_item_d = sel;
                        credit_d    = credit_q - sel_price;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (coin_en) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_en;
                state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = coin_en;
                if (chg_ack) begin
                    credit_d = credit_q - CREDIT_W'(coin_value(chg_coin_q));
                    if (credit_d == '0) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Offered coin follows next-cycle credit, so it only moves after an ack.
        chg_valid_d = (state_d == S_CHANGE);
        chg_coin_d  = chg_valid_d ? greedy_coin : COIN_5;
        busy_d      = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            dispense_q    <= 1'b0;
            disp_item_q   <= '0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            disp_item_q   <= disp_item_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= busy_d;
        end
    end

    assign dispense    = dispense_q;
    assign disp_item   = disp_item_q;
    assign chg_valid   = chg_valid_q;
    assign chg_coin    = chg_coin_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vending_multi.sv
// Self-checking bench for vending_multi: directed scenarios then random traffic
// against a money-counting reference model.
module tb_vending_multi;

    localparam int N     = 4;
    localparam int CW    = 8;
    localparam int MAXC  = 100;
    localparam int SW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          coin_en = 1'b0;
    logic [1:0]    coin_val = '0;
    logic          sel_en = 1'b0;
    logic [SW-1:0] sel = '0;
    logic          cancel = 1'b0;
    logic [N-1:0]  stock_empty = '0;
    logic          chg_ack = 1'b0;
    logic          dispense;
    logic [SW-1:0] disp_item;
    logic          chg_valid;
    logic [1:0]    chg_coin;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          sel_err;
    logic          busy;

    vending_multi #(
        .N_ITEMS   (N),
        .CREDIT_W  (CW),
        .MAX_CREDIT(MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_en    (coin_en),
        .coin_val   (coin_val),
        .sel_en     (sel_en),
        .sel        (sel),
        .cancel     (cancel),
        .stock_empty(stock_empty),
        .chg_ack    (chg_ack),
        .dispense   (dispense),
        .disp_item  (disp_item),
        .chg_valid  (chg_valid),
        .chg_coin   (chg_coin),
        .credit     (credit),
        .coin_reject(coin_reject),
        .sel_err    (sel_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: money held, whether a vend just happened, whether change is owed.
    int price [N] = '{25, 20, 15, 10};
    int m_money    = 0;
    bit m_open     = 0;   // customer session with credit, accepting selections
    bit m_vended   = 0;   // the cycle right after an accepted selection
    bit m_refund   = 0;   // paying money back coin by coin

    int e_dispense, e_item, e_reject, e_selerr;

    function automatic int worth(input int code);
        if (code == 0) return 5;
        if (code == 1) return 10;
        if (code == 2) return 25;
        return -1;
    endfunction

    function automatic int biggest_coin(input int money);
        if (money >= 25) return 25;
        if (money >= 10) return 10;
        return 5;
    endfunction

    function automatic int code_of(input int value);
        return (value == 25) ? 2 : (value == 10) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("dispense",    32'(dispense),    32'(e_dispense));
        chk("disp_item",   32'(disp_item),   32'(e_item));
        chk("coin_reject", 32'(coin_reject), 32'(e_reject));
        chk("sel_err",     32'(sel_err),     32'(e_selerr));
        chk("credit",      32'(credit),      32'(m_money));
        chk("chg_valid",   32'(chg_valid),   32'(m_refund));
        chk("chg_coin",    32'(chg_coin),    m_refund ? 32'(code_of(biggest_coin(m_money))) : 32'd0);
        chk("busy",        32'(busy),        32'(m_vended | m_refund));
    endtask

    // Predict one clock of behaviour, apply inputs, clock, then compare.
    task automatic step(input bit ce, input int cv, input bit se, input int s,
                        input bit cn, input bit ak);
        int w;
        bit coin_fits;
        e_dispense = 0; e_item = 0; e_reject = 0; e_selerr = 0;
        w = worth(cv);
        coin_fits = (w > 0) && (m_money + w <= MAXC);
        if (m_vended) begin
            e_reject = ce;
            m_vended = 0;
            m_refund = (m_money > 0);
        end else if (m_refund) begin
            e_reject = ce;
            if (ak) begin
                m_money -= biggest_coin(m_money);
                if (m_money == 0) m_refund = 0;
            end
        end else if (m_open && cn) begin
            e_reject = ce;
            m_open   = 0;
            m_refund = 1;
        end else if (m_open && se) begin
            e_reject = ce;
            if (s < N && !stock_empty[s] && m_money >= price[s]) begin
                e_dispense = 1;
                e_item     = s;
                m_money   -= price[s];
                m_open     = 0;
                m_vended   = 1;
            end else begin
                e_selerr = 1;
            end
        end else if (ce) begin
            if (coin_fits) begin
                m_money += w;
                m_open   = 1;
            end else begin
                e_reject = 1;
            end
        end
        coin_en  = ce;
        coin_val = 2'(cv);
        sel_en   = se;
        sel      = SW'(s);
        cancel   = cn;
        chg_ack  = ak;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int code);
        step(1, code, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (m_refund || m_vended); i++) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        m_money = 0; m_open = 0; m_vended = 0; m_refund = 0;
        e_dispense = 0; e_item = 0; e_reject = 0; e_selerr = 0;
        check_outputs();
        coin_en = 0; sel_en = 0; cancel = 0; chg_ack = 0; stock_empty = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        e_dispense = 0; e_item = 0; e_reject = 0; e_selerr = 0;
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // 10 + 5 buys item 2 exactly, no change owed
        coin(1);
        coin(0);
        step(0, 0, 1, 2, 0, 0);
        idle_step();
        idle_step();

        // 25 + 25 buys item 0, 25 back
        coin(2);
        coin(2);
        step(0, 0, 1, 0, 0, 0);
        idle_step();
        step(0, 0, 0, 0, 0, 1);
        idle_step();

        // refund held while ack stays low
        coin(2);
        step(0, 0, 0, 0, 1, 0);
        repeat (5) idle_step();
        step(0, 0, 0, 0, 0, 1);
        idle_step();

        // refused selections: short credit, sold out
        coin(1);
        step(0, 0, 1, 0, 0, 0);
        coin(0);
        coin(1);
        stock_empty = 4'b1000;
        step(0, 0, 1, 3, 0, 0);
        stock_empty = '0;
        step(0, 0, 0, 0, 1, 0);
        drain();

        // credit ceiling and bad coin code
        coin(2); coin(2); coin(2); coin(1); coin(1);
        coin(1);
        coin(3);
        step(0, 0, 0, 0, 1, 0);
        drain();
        idle_step();

        // selection beats a same-cycle coin
        coin(1);
        coin(1);
        step(1, 1, 1, 3, 0, 0);
        drain();
        idle_step();

        // coin offered while paying out is bounced
        coin(2);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 1, 0);
        drain();

        // reset during payout discards the debt
        coin(1);
        coin(0);
        step(0, 0, 0, 0, 1, 0);
        idle_step();
        apply_reset();
        idle_step();

        for (int i = 0; i < 400; i++) begin
            stock_empty = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step($urandom_range(0, 9) < 4, $urandom_range(0, 3),
                 $urandom_range(0, 9) < 2, $urandom_range(0, N - 1),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_multi.md
VENDING_MULTI -- requirements
Module: vending_multi

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4, number of selectable products (2..16).
REQ-002 SHALL have parameter CREDIT_W, default 8, credit register width in bits.
REQ-003 SHALL have parameter MAX_CREDIT, default 100, highest credit value accepted (multiple of 5, below 2**CREDIT_W).
REQ-004 SHALL have parameter PRICES, default {25,20,15,10}, N_ITEMS*CREDIT_W packed prices; item i is in slice i; each price is a nonzero multiple of 5.
REQ-005 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port coin_en, input, 1 bit, coin present this cycle.
REQ-008 SHALL have port coin_val, input, 2 bits, coin code: 0=5, 1=10, 2=25, 3=invalid.
REQ-009 SHALL have port sel_en, input, 1 bit, product selection strobe.
REQ-010 SHALL have port sel, input, SEL_W=$clog2(N_ITEMS) bits, selected item index.
REQ-011 SHALL have port cancel, input, 1 bit, refund request.
REQ-012 SHALL have port stock_empty, input, N_ITEMS bits, per-item sold-out flags.
REQ-013 SHALL have port chg_ack, input, 1 bit, change coin taken by payout mechanism.
REQ-014 SHALL have port dispense, output, 1 bit, one-cycle vend pulse.
REQ-015 SHALL have port disp_item, output, SEL_W bits, item index, valid with dispense.
REQ-016 SHALL have port chg_valid, output, 1 bit, change coin offered.
REQ-017 SHALL have port chg_coin, output, 2 bits, offered change coin code.
REQ-018 SHALL have port credit, output, CREDIT_W bits, current credit.
REQ-019 SHALL have port coin_reject, output, 1 bit, one-cycle pulse: coin returned unaccepted.
REQ-020 SHALL have port sel_err, output, 1 bit, one-cycle pulse: selection refused.
REQ-021 SHALL have port busy, output, 1 bit, high in VEND or CHANGE.

Function
REQ-022 SHALL implement states IDLE, CREDIT, VEND, CHANGE; all outputs registered.
REQ-023 IDLE/CREDIT: valid coin_en SHALL add coin value to credit next cycle and go to CREDIT; code 3 or credit+value > MAX_CREDIT -> coin_reject, credit unchanged.
REQ-024 CREDIT: sel_en with stock_empty[sel]=1, sel>=N_ITEMS, or credit<price[sel] SHALL pulse sel_err and stay in CREDIT.
REQ-025 CREDIT: accepted sel_en SHALL enter VEND; VEND lasts exactly one cycle with dispense=1, disp_item=sel, credit reduced by price[sel].
REQ-026 After VEND: credit>0 -> CHANGE, else IDLE.
REQ-027 CREDIT: cancel SHALL enter CHANGE with credit unchanged; cancel in IDLE ignored.
REQ-028 CHANGE: chg_valid=1, chg_coin = largest coin (25,10,5) <= credit; chg_coin held stable until chg_ack.
REQ-029 CHANGE: chg_ack with chg_valid SHALL subtract the coin value from credit that cycle; credit reaching 0 -> IDLE, chg_valid low next cycle.
REQ-030 Same-cycle priority in CREDIT: cancel > sel_en > coin_en; a coin dropped by priority SHALL pulse coin_reject.
REQ-031 coin_en during VEND or CHANGE SHALL pulse coin_reject; sel_en and cancel there ignored.
REQ-032 sel_err and coin_reject MAY assert in the same cycle; dispense and sel_err never do.
REQ-033 credit SHALL never exceed MAX_CREDIT nor underflow.

Reset
REQ-034 rst low SHALL immediately force IDLE, credit=0, dispense=0, disp_item=0, chg_valid=0, chg_coin=0, coin_reject=0, sel_err=0, busy=0.
REQ-035 Reset mid-CHANGE SHALL discard remaining credit; no change is owed after reset.
REQ-036 Release SHALL be taken synchronously to clk; first active edge sees IDLE.

Structure
REQ-037 Package vend_pkg SHALL hold the state enum, coin code constants and coin value constants (5, 10, 25).
REQ-038 Sub-module vend_change_sel SHALL compute greedy chg_coin from credit (combinational); all state logic stays in vending_multi.

Verification
REQ-039 Coins 10,5 then sel=2 (price 15) -> credit 10,15; dispense=1, disp_item=2; credit 0; back to IDLE; no chg_valid.
REQ-040 Coins 25,25 then sel=0 (price 25) -> dispense; chg_valid with chg_coin=25; ack -> credit 0, IDLE.
REQ-041 Coin 25 then cancel; chg_ack held low 5 cycles -> chg_coin stays 25, credit stays 25; ack -> IDLE.
REQ-042 Credit 10, sel=0 -> sel_err, stays CREDIT; stock_empty[3]=1 with credit 25, sel=3 -> sel_err, no dispense.
REQ-043 Credit 95, coin 10 -> coin_reject, credit 95; coin_val=3 -> coin_reject; same-cycle sel_en+coin_en with credit 20, sel=3 -> dispense and coin_reject.
REQ-044 rst low during CHANGE with credit 15 -> next sample all outputs 0, IDLE.
